// File: rtl/xadc_drp_ctrl.sv
// XADC DRP controller: writes the three config registers after reset, then reads EOC
// results and services host DRP accesses. Optional DRDY timeout via XADC_DRP_TIMEOUT_EN.
module xadc_drp_ctrl #(
    parameter logic [15:0] CFG0 = 16'h0000,
    parameter logic [15:0] CFG1 = 16'h2000,
    parameter logic [15:0] CFG2 = 16'h0400
`ifdef XADC_DRP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic        dclk_in,
    input  logic        reset_in,
    input  logic        eoc_in,
    input  logic [4:0]  channel_in,
    output logic [6:0]  daddr_out,
    output logic        den_out,
    output logic        dwe_out,
    output logic [15:0] di_out,
    input  logic [15:0] do_in,
    input  logic        drdy_in,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [6:0]  host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        sample_valid,
    output logic [4:0]  sample_chan,
    output logic [11:0] sample_data,
    output logic        init_done,
`ifdef XADC_DRP_TIMEOUT_EN
    output logic        drp_timeout,
`endif
    output logic        overrun
);

    typedef enum logic [2:0] {INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT_DRDY} state_t;

    state_t      state_q, state_d;
    logic [1:0]  init_idx_q, init_idx_d;
    logic        pend_q, pend_d;
    logic [4:0]  pchan_q, pchan_d;
    logic        host_acc_q, host_acc_d;
    logic [6:0]  daddr_q, daddr_d;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [15:0] di_q, di_d;
    logic        host_ack_q, host_ack_d;
    logic [15:0] host_rdata_q, host_rdata_d;
    logic        sample_valid_q, sample_valid_d;
    logic [4:0]  sample_chan_q, sample_chan_d;
    logic [11:0] sample_data_q, sample_data_d;
    logic        init_done_q, init_done_d;
    logic        overrun_q, overrun_d;

    logic        in_wait, acc_ok, acc_tmo, acc_done;
    logic        take_pend, take_eoc_direct, take_host;
    logic [15:0] cfg_sel;

    // drdy only counts while an access is outstanding, so stale strobes are ignored
    assign in_wait  = (state_q == INIT_WAIT) || (state_q == WAIT_DRDY);
    assign acc_ok   = in_wait && drdy_in;
    assign acc_done = acc_ok || acc_tmo;

`ifdef XADC_DRP_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    assign acc_tmo     = in_wait && !drdy_in && (cnt_q == 32'(TIMEOUT_CYC - 1));
    assign cnt_d       = in_wait ? cnt_q + 32'd1 : 32'd0;
    assign tmo_d       = tmo_q | acc_tmo;
    assign drp_timeout = tmo_q;

    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`else
    assign acc_tmo = 1'b0;
`endif

    // A same-cycle eoc_in in IDLE is read directly and still beats the host
    assign take_pend       = (state_q == IDLE) && pend_q;
    assign take_eoc_direct = (state_q == IDLE) && !pend_q && eoc_in;
    assign take_host       = (state_q == IDLE) && !pend_q && !eoc_in && host_req && !host_ack_q;

    always_comb begin
        case (init_idx_q)
            2'd0:    cfg_sel = CFG0;
            2'd1:    cfg_sel = CFG1;
            default: cfg_sel = CFG2;
        endcase
    end

    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) state_q <= INIT_ISSUE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT_ISSUE: if (den_q) state_d = INIT_WAIT;
            INIT_WAIT:  if (acc_done) state_d = (init_idx_q == 2'd2) ? IDLE : INIT_ISSUE;
            IDLE:       if (take_pend || take_eoc_direct || take_host) state_d = ISSUE;
            ISSUE:      state_d = WAIT_DRDY;
            WAIT_DRDY:  if (acc_done) state_d = IDLE;
            default:    state_d = INIT_ISSUE;
        endcase
    end

    always_comb begin
        init_idx_d     = init_idx_q;
        pend_d         = pend_q;
        pchan_d        = pchan_q;
        host_acc_d     = host_acc_q;
        daddr_d        = daddr_q;
        den_d          = 1'b0;
        dwe_d          = dwe_q;
        di_d           = di_q;
        host_ack_d     = 1'b0;
        host_rdata_d   = host_rdata_q;
        sample_valid_d = 1'b0;
        sample_chan_d  = sample_chan_q;
        sample_data_d  = sample_data_q;
        init_done_d    = init_done_q;
        overrun_d      = overrun_q;

        if (take_pend) pend_d = 1'b0;
        if (eoc_in && !take_eoc_direct) begin
            pend_d  = 1'b1;
            pchan_d = channel_in;
            if (pend_q && !take_pend) overrun_d = 1'b1;
        end

        case (state_q)
            INIT_ISSUE: if (!den_q) begin
                daddr_d    = 7'h40 + {5'b0, init_idx_q};
                di_d       = cfg_sel;
                dwe_d      = 1'b1;
                den_d      = 1'b1;
                host_acc_d = 1'b0;
            end
            INIT_WAIT: if (acc_done) begin
                dwe_d      = 1'b0;
                init_idx_d = init_idx_q + 2'd1;
                if (init_idx_q == 2'd2) init_done_d = 1'b1;
            end
            IDLE: begin
                if (take_pend || take_eoc_direct) begin
                    daddr_d    = {2'b00, take_pend ? pchan_q : channel_in};
                    dwe_d      = 1'b0;
                    di_d       = 16'h0000;
                    den_d      = 1'b1;
                    host_acc_d = 1'b0;
                end else if (take_host) begin
                    daddr_d    = host_addr;
                    dwe_d      = host_we;
                    di_d       = host_wdata;
                    den_d      = 1'b1;
                    host_acc_d = 1'b1;
                end
            end
            WAIT_DRDY: if (acc_done) begin
                dwe_d = 1'b0;
                if (host_acc_q) begin
                    host_ack_d   = 1'b1;
                    host_rdata_d = acc_tmo ? 16'hDEAD : (dwe_q ? 16'h0000 : do_in);
                end else if (acc_ok) begin
                    sample_valid_d = 1'b1;
                    sample_chan_d  = daddr_q[4:0];
                    sample_data_d  = do_in[15:4];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            init_idx_q     <= '0;
            pend_q         <= 1'b0;
            pchan_q        <= '0;
            host_acc_q     <= 1'b0;
            daddr_q        <= '0;
            den_q          <= 1'b0;
            dwe_q          <= 1'b0;
            di_q           <= '0;
            host_ack_q     <= 1'b0;
            host_rdata_q   <= '0;
            sample_valid_q <= 1'b0;
            sample_chan_q  <= '0;
            sample_data_q  <= '0;
            init_done_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            init_idx_q     <= init_idx_d;
            pend_q         <= pend_d;
            pchan_q        <= pchan_d;
            host_acc_q     <= host_acc_d;
            daddr_q        <= daddr_d;
            den_q          <= den_d;
            dwe_q          <= dwe_d;
            di_q           <= di_d;
            host_ack_q     <= host_ack_d;
            host_rdata_q   <= host_rdata_d;
            sample_valid_q <= sample_valid_d;
            sample_chan_q  <= sample_chan_d;
            sample_data_q  <= sample_data_d;
            init_done_q    <= init_done_d;
            overrun_q      <= overrun_d;
        end
    end

    assign daddr_out    = daddr_q;
    assign den_out      = den_q;
    assign dwe_out      = dwe_q;
    assign di_out       = di_q;
    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign sample_valid = sample_valid_q;
    assign sample_chan  = sample_chan_q;
    assign sample_data  = sample_data_q;
    assign init_done    = init_done_q;
    assign overrun      = overrun_q;

endmodule
